fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 100, number of valid instruction-memory words (word-addressed).
REQ-002 SHALL have parameter RESET_PC, default 32'd0, PC value loaded at reset and held in IDLE.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins fetching.
REQ-007 SHALL have port stop  input  1  requests halt of fetching.
REQ-008 SHALL have port freeze  input  1  hazard stall; holds PC and IF/ID.
REQ-009 SHALL have port branch_taken  input  1  redirect request from the branch/jump resolver.
REQ-010 SHALL have port branch_target  input  32  word address to redirect to.
REQ-011 SHALL have port imem_addr  output  32  instruction-memory address (word index).
REQ-012 SHALL have port imem_instr  input  32  instruction-memory read data, combinational from imem_addr.
REQ-013 SHALL have port ifid_instr  output  32  registered fetched instruction.
REQ-014 SHALL have port ifid_pc1  output  32  registered PC+1 of the fetched instruction.
REQ-015 SHALL have port ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-016 SHALL have port halted  output  1  high in HALT state.
REQ-017 SHALL have port fault  output  1  out-of-range fetch flag (see Configuration).

Function
REQ-018 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on stop; HALT is left only by reset.
REQ-019 SHALL drive imem_addr = PC combinationally in every state.
REQ-020 In RUN with branch_taken=1: PC<=branch_target, ifid_instr<=32'h0 (NOP), ifid_valid<=0; branch_taken has priority over freeze and stop.
REQ-021 In RUN with branch_taken=0, freeze=0, stop=0: ifid_instr<=imem_instr, ifid_pc1<=PC+1, ifid_valid<=1, PC<=PC+1; one-cycle fetch latency, one instruction per cycle.
REQ-022 In RUN with freeze=1, branch_taken=0: PC, ifid_instr, ifid_pc1, ifid_valid SHALL hold.
REQ-023 stop in RUN (branch_taken=0) SHALL enter HALT next edge with ifid_valid<=0, PC held; stop and freeze together -> HALT.
REQ-024 In IDLE and HALT: PC held, ifid_valid=0, branch_taken/freeze/stop ignored; start ignored outside IDLE.
REQ-025 PC+1 SHALL wrap modulo 2^32 (32'hFFFFFFFF -> 32'h0).
REQ-026 start and stop asserted together in IDLE SHALL enter RUN (stop evaluated only in RUN).
REQ-027 halted SHALL be a registered decode of state HALT.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, PC=RESET_PC, ifid_instr=0, ifid_pc1=0, ifid_valid=0, halted=0, fault=0, regardless of clk.
REQ-029 Reset asserted mid-RUN SHALL discard the in-flight fetch; after release, no fetch until a new start.

Configuration
REQ-030 Macro FETCH_BOUND_CHECK_EN SHALL enable range checking: in RUN, if PC >= MEM_DEPTH with branch_taken=0 and freeze=0, next edge enters HALT, fault<=1 (sticky until reset), ifid_valid<=0, imem_instr not captured.
REQ-031 A branch_target >= MEM_DEPTH SHALL be accepted; the fault triggers when that PC is fetched (REQ-030).
REQ-032 Without FETCH_BOUND_CHECK_EN: no range check, fault tied to 0, any PC fetched per REQ-021.

Verification
REQ-033 Reset, start; memory holds add R4<-R3+R2 at 0, add R5<-R4+R1 at 1 -> imem_addr 0,1,2 on successive cycles; ifid_instr follows one cycle later, ifid_pc1=1,2, ifid_valid=1.
REQ-034 freeze high 2 cycles at PC=3 -> imem_addr stays 3, IF/ID unchanged 2 cycles, resumes at 4 after release.
REQ-035 branch_taken with target 16 at PC=6, freeze also high -> next cycle imem_addr=16, ifid_valid=0, ifid_instr=0; following cycle ifid_pc1=17.
REQ-036 With FETCH_BOUND_CHECK_EN, MEM_DEPTH=100: run to PC=100 -> HALT, fault=1, halted=1, ifid_valid=0; start ignored; without macro PC reaches 101 and fault stays 0.
REQ-037 rst_n low between clock edges during RUN at PC=5 -> outputs cleared immediately, PC=0, state IDLE; stop pulse in RUN -> halted=1 next cycle.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch stage: IDLE/RUN/HALT control, PC sequencing and the IF/ID register.
// Define FETCH_BOUND_CHECK_EN to halt with a sticky fault when fetching at PC >= MEM_DEPTH.
module fetch_controller #(
    parameter int unsigned MEM_DEPTH = 100,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc1,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc_inc_s;
    logic        oob_s;

    // Memory is read combinationally straight from the PC.
    assign imem_addr = pc_r;
    assign pc_inc_s  = pc_r + 32'd1;

`ifdef FETCH_BOUND_CHECK_EN
    assign oob_s = (pc_r >= 32'(MEM_DEPTH));

    // Sticky out-of-range flag; a redirect or stall pre-empts the check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if ((state_r == RUN) && oob_s && !branch_taken && !freeze) begin
            fault <= 1'b1;
        end else begin
            fault <= fault;
        end
    end
`else
    assign oob_s = 1'b0;
    assign fault = 1'b0;
`endif

    // Control FSM together with the PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            ifid_instr <= 32'h0;
            ifid_pc1   <= 32'h0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ifid_valid <= 1'b0;
                    halted     <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        // Redirect squashes the instruction fetched this cycle.
                        pc_r       <= branch_target;
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (oob_s && !freeze) begin
                        state_r    <= HALT;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                    end else if (stop) begin
                        state_r    <= HALT;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                    end else if (freeze) begin
                        pc_r       <= pc_r;
                        ifid_valid <= ifid_valid;
                    end else begin
                        ifid_instr <= imem_instr;
                        ifid_pc1   <= pc_inc_s;
                        ifid_valid <= 1'b1;
                        pc_r       <= pc_inc_s;
                    end
                end
                HALT: begin
                    state_r    <= HALT;
                    halted     <= 1'b1;
                    ifid_valid <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    halted     <= 1'b0;
                    ifid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
